logic_unit_bist: RTL and testbench

- Built-in self-test engine for the n-bit logic unit, the hardware counterpart of the directed logic-unit bench.
- Drives A, B and sel into the unit, reads the combinational OUT back, and compacts every result into a MISR signature.
- Compares the final signature to a golden value and reports pass or fail.
- Sits beside the ALU and is used for power-on test and silicon debug.

---
 rtl/logic_unit_bist.sv | 141 ++++++++++++++
 tb/tb_logic_unit_bist.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_bist.sv
// BIST engine for the n-bit logic unit. It sweeps LFSR operand pairs through every sel code, compacts OUT into a MISR and compares the result with GOLDEN.
// Optional per-cycle response checker: define LOGIC_BIST_CHECK_EN.
module logic_unit_bist #(
  parameter int             n       = 32,
  parameter int             NUM_VEC = 16,
  parameter int             IDXW    = 8,
  parameter logic [n-1:0]   POLY    = 32'h80200003,
  parameter logic [n-1:0]   SEED_A  = 32'h00000033,
  parameter logic [n-1:0]   SEED_B  = 32'h000001E6,
  parameter logic [n-1:0]   GOLDEN  = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [n-1:0]    A,
  output logic [n-1:0]    B,
  output logic [1:0]      sel,
  input  logic [n-1:0]    OUT,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [n-1:0]    signature,
  output logic            err,
  output logic [IDXW-1:0] err_index
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDXW-1:0] LAST       = IDXW'(4 * NUM_VEC - 1);
  localparam logic [n-1:0]    SEED_A_EFF = (SEED_A == '0) ? n'(1) : SEED_A;
  localparam logic [n-1:0]    SEED_B_EFF = (SEED_B == '0) ? n'(1) : SEED_B;

  function automatic logic [n-1:0] lfsr_step(input logic [n-1:0] v);
    return {v[n-2:0], ^(v & POLY)};
  endfunction

  state_t          r_state, w_next;
  logic [n-1:0]    r_a, r_b, r_sig;
  logic [1:0]      r_sel;
  logic [IDXW-1:0] r_idx;
  logic            r_pass;
  logic            w_start, w_run, w_last, w_pass_next;
  logic [n-1:0]    w_sig_next;

  assign w_start    = start && (r_state != S_RUN);
  assign w_run      = (r_state == S_RUN);
  assign w_last     = w_run && (r_idx == LAST);
  assign w_sig_next = lfsr_step(r_sig) ^ OUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN:          if (r_idx == LAST) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Operand/select sequencer and MISR; operands advance only when sel wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sel  <= 2'b00;
      r_sig  <= '0;
      r_idx  <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_a    <= SEED_A_EFF;
      r_b    <= SEED_B_EFF;
      r_sel  <= 2'b00;
      r_sig  <= '0;
      r_idx  <= '0;
      r_pass <= 1'b0;
    end else if (w_run) begin
      r_sig <= w_sig_next;
      r_idx <= r_idx + IDXW'(1);
      r_sel <= r_sel + 2'd1;
      if (r_sel == 2'b11) begin
        r_a <= lfsr_step(r_a);
        r_b <= lfsr_step(r_b);
      end
      if (w_last) r_pass <= w_pass_next;
    end
  end

`ifdef LOGIC_BIST_CHECK_EN
  logic [n-1:0]    w_exp;
  logic            w_mismatch;
  logic            r_err;
  logic [IDXW-1:0] r_err_idx;

  always_comb begin
    w_exp = '0;
    case (r_sel)
      2'b00:   w_exp = r_a & r_b;
      2'b01:   w_exp = r_a | r_b;
      2'b10:   w_exp = r_a ^ r_b;
      default: w_exp = ~(r_a | r_b);
    endcase
  end

  assign w_mismatch  = w_run && (OUT != w_exp);
  // A mismatch on the final cycle must still veto pass, hence w_mismatch here.
  assign w_pass_next = (w_sig_next == GOLDEN) && !r_err && !w_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (w_start) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (w_mismatch && !r_err) begin
      r_err     <= 1'b1;
      r_err_idx <= r_idx;
    end
  end

  assign err       = r_err;
  assign err_index = r_err_idx;
`else
  assign w_pass_next = (w_sig_next == GOLDEN);
  assign err         = 1'b0;
  assign err_index   = '0;
`endif

  assign A         = r_a;
  assign B         = r_b;
  assign sel       = r_sel;
  assign signature = r_sig;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;

endmodule

// File: tb/tb_logic_unit_bist.sv
// Bench for logic_unit_bist: behavioural logic unit with fault injection, reference signature model, directed and randomized runs.
module tb_logic_unit_bist;

  localparam int          NV      = 2;
  localparam int          L       = 4 * NV;
  localparam logic [31:0] TB_POLY = 32'h80200003;
  localparam logic [31:0] TB_SA   = 32'h00000033;
  localparam logic [31:0] TB_SB   = 32'h000001E6;

  function automatic logic [31:0] step(input logic [31:0] v);
    return {v[30:0], ^(v & TB_POLY)};
  endfunction

  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [31:0] op_a(input int v);
    logic [31:0] x;
    x = TB_SA;
    for (int i = 0; i < v; i++) x = step(x);
    return x;
  endfunction

  function automatic logic [31:0] op_b(input int v);
    logic [31:0] x;
    x = TB_SB;
    for (int i = 0; i < v; i++) x = step(x);
    return x;
  endfunction

  function automatic logic [31:0] model_sig(input int fidx, input int fbit);
    logic [31:0] s, o;
    s = 32'h0;
    for (int k = 0; k < L; k++) begin
      o = lu(op_a(k / 4), op_b(k / 4), 2'(k % 4));
      if (k == fidx) o = o ^ (32'h1 << fbit);
      s = step(s) ^ o;
    end
    return s;
  endfunction

  localparam logic [31:0] TB_GOLDEN = model_sig(-1, 0);

  logic        clk, rst, start;
  logic [31:0] A, B, tb_out, signature, fault_mask;
  logic [1:0]  sel;
  logic        busy, done, pass, err;
  logic [7:0]  err_index;
  int          n_tests, n_fail;

  logic_unit_bist #(
    .n(32), .NUM_VEC(NV), .IDXW(8), .POLY(TB_POLY),
    .SEED_A(TB_SA), .SEED_B(TB_SB), .GOLDEN(TB_GOLDEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sel(sel), .OUT(tb_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .err(err), .err_index(err_index)
  );

  always_comb tb_out = lu(A, B, sel) ^ fault_mask;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input int fidx, input int fbit, input int hold);
    int busy_cnt;
    logic exp_err;
    @(negedge clk);
    start = 1'b1;
    fault_mask = '0;
    @(negedge clk);
    busy_cnt = 0;
    for (int k = 0; k < L; k++) begin
      start = (k < hold);
      if (k == 0) begin
        check("first_sig", signature, 32'h0);
        check("first_done", 32'(done), 32'h0);
        check("first_pass", 32'(pass), 32'h0);
      end
      check("run_busy", 32'(busy), 32'h1);
      check("run_A", A, op_a(k / 4));
      check("run_B", B, op_b(k / 4));
      check("run_sel", 32'(sel), 32'(k % 4));
      if (busy) busy_cnt++;
      fault_mask = (k == fidx) ? (32'h1 << fbit) : 32'h0;
      @(negedge clk);
    end
    start = 1'b0;
    fault_mask = '0;
    exp_err = (fidx >= 0);
    check("end_done", 32'(done), 32'h1);
    check("end_busy", 32'(busy), 32'h0);
    check("busy_cycles", 32'(busy_cnt), 32'(L));
    check("end_sig", signature, model_sig(fidx, fbit));
    check("end_pass", 32'(pass), 32'(!exp_err));
    check("end_sig_vs_golden", 32'(signature != TB_GOLDEN), 32'(exp_err));
    check("end_A", A, op_a(NV));
    check("end_B", B, op_b(NV));
    check("end_sel", 32'(sel), 32'h0);
`ifdef LOGIC_BIST_CHECK_EN
    check("end_err", 32'(err), 32'(exp_err));
    if (exp_err) check("end_err_index", 32'(err_index), 32'(fidx));
`else
    check("end_err", 32'(err), 32'h0);
    check("end_err_index", 32'(err_index), 32'h0);
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    fault_mask = '0;

    // Asynchronous reset applied between clock edges.
    #3 rst = 1'b1;
    #1;
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_sig", signature, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    do_run(-1, 0, 0);
    do_run(6, 5, 0);

    // Abort mid-run with reset, then confirm a clean run afterwards.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("abort_sig", signature, 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_A", A, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'h0);
    check("abort_idle_done", 32'(done), 32'h0);

    do_run(-1, 0, 0);
    do_run(-1, 0, $urandom_range(L - 2, 1));
    for (int r = 0; r < 3; r++)
      do_run($urandom_range(L - 1, 0), $urandom_range(31, 0), $urandom_range(L - 2, 0));
    do_run(-1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
